// File: rtl/jtframe_4wayjoy_pkg.sv
// rtl/jtframe_4wayjoy_pkg.sv - direction bit indices, direction type and opposite-cancel helper
package jtframe_4wayjoy_pkg;

   localparam int RIGHT = 0;
   localparam int LEFT  = 1;
   localparam int DOWN  = 2;
   localparam int UP    = 3;

   typedef logic [3:0] dir_t;

   localparam dir_t HORZ_MASK = 4'b0011;
   localparam dir_t VERT_MASK = 4'b1100;

   // Pushing both ways on one axis is read as not pushing that axis at all
   function automatic dir_t cancel_opposite(input dir_t d);
      dir_t r;
      r = d;
      if (d[RIGHT] && d[LEFT]) begin
         r[RIGHT] = 1'b0;
         r[LEFT]  = 1'b0;
      end
      if (d[DOWN] && d[UP]) begin
         r[DOWN] = 1'b0;
         r[UP]   = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/jtframe_4wayjoy_filter.sv
// rtl/jtframe_4wayjoy_filter.sv - input stability filter, dout follows din after 2^FILT_W equal samples
module jtframe_4wayjoy_filter
   import jtframe_4wayjoy_pkg::*;
#(
   parameter int FILT_W = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   output logic [3:0] dout
);

   dir_t              held;
   logic [FILT_W-1:0] cnt;

   // cnt holds how many consecutive samples of held have been seen, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held <= '0;
         cnt  <= '0;
         dout <= '0;
      end else if (din != held) begin
         held <= din;
         cnt  <= FILT_W'(1);
      end else begin
         if (&cnt)
            dout <= held;
         else
            cnt <= cnt + FILT_W'(1);
      end
   end

endmodule

// File: rtl/jtframe_4wayjoy.sv
// rtl/jtframe_4wayjoy.sv - 4-way joystick restriction; JTFRAME_4WAY_FILTER_EN adds an input stability filter
module jtframe_4wayjoy
   import jtframe_4wayjoy_pkg::*;
#(
   parameter int FILT_W = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] joy8way,
   output logic [3:0] joy4way
);

   if (FILT_W < 1) begin : g_filt_w_check
      $error("FILT_W must be at least 1");
   end

   dir_t joy_in;

`ifdef JTFRAME_4WAY_FILTER_EN
   jtframe_4wayjoy_filter #(
      .FILT_W (FILT_W)
   ) u_filter (
      .clk  (clk),
      .rst  (rst),
      .din  (joy8way),
      .dout (joy_in)
   );
`else
   assign joy_in = joy8way;
`endif

   dir_t joy_c;
   dir_t last;
   dir_t last_nxt;
   dir_t dir_nxt;
   dir_t out_nxt;
   logic horz;
   logic vert;

   // On a diagonal the direction already held wins; a fresh diagonal resolves to the vertical bit
   always_comb begin
      joy_c    = cancel_opposite(joy_in);
      horz     = |(joy_c & HORZ_MASK);
      vert     = |(joy_c & VERT_MASK);
      dir_nxt  = '0;
      last_nxt = '0;
      if (horz && vert) begin
         if ((last & joy_c) != '0) begin
            dir_nxt  = last;
            last_nxt = last;
         end else begin
            dir_nxt  = joy_c & VERT_MASK;
            last_nxt = joy_c & VERT_MASK;
         end
      end else begin
         dir_nxt  = joy_c;
         last_nxt = joy_c;
      end
      out_nxt = enable ? dir_nxt : joy_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         joy4way <= '0;
         last    <= '0;
      end else begin
         joy4way <= out_nxt;
         last    <= last_nxt;
      end
   end

endmodule

// File: tb/tb_jtframe_4wayjoy.sv
// tb/tb_jtframe_4wayjoy.sv - bench for jtframe_4wayjoy, default build and JTFRAME_4WAY_FILTER_EN build
module tb_jtframe_4wayjoy;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] joy8way;
   logic [3:0] joy4way;

   int vectors    = 0;
   int miscompares = 0;

   logic [3:0] m_last = 4'b0000;
   logic [3:0] m_exp;

   always #5 clk = ~clk;

   jtframe_4wayjoy #(
      .FILT_W (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .joy8way (joy8way),
      .joy4way (joy4way)
   );

   task automatic check(input string tag, input logic [3:0] exp);
      vectors++;
      assert (joy4way === exp) else begin
         miscompares++;
         $error("FAIL %s: joy4way=%b expected %b", tag, joy4way, exp);
      end
   endtask

   // Reference: list the surviving directions after axis cancellation, then pick one
   task automatic model(input logic en, input logic [3:0] j, output logic [3:0] res);
      int         hx;
      int         vy;
      logic [3:0] cand[$];
      logic [3:0] pick;
      hx = int'(j[0]) - int'(j[1]);
      vy = int'(j[2]) - int'(j[3]);
      if (hx ==  1) cand.push_back(4'b0001);
      if (hx == -1) cand.push_back(4'b0010);
      if (vy ==  1) cand.push_back(4'b0100);
      if (vy == -1) cand.push_back(4'b1000);
      if (cand.size() == 0) begin
         pick   = 4'b0000;
         m_last = 4'b0000;
      end else if (cand.size() == 1) begin
         pick   = cand[0];
         m_last = cand[0];
      end else if (m_last == cand[0] || m_last == cand[1]) begin
         pick = m_last;
      end else begin
         pick   = cand[1];
         m_last = cand[1];
      end
      res = en ? pick : j;
   endtask

   task automatic apply(input logic en, input logic [3:0] j);
      enable  = en;
      joy8way = j;
      model(en, j, m_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic en, input logic [3:0] j, input logic [3:0] exp);
      apply(en, j);
      check(tag, exp);
   endtask

   initial begin
      rst     = 1'b0;
      enable  = 1'b0;
      joy8way = 4'b1111;
      #12;
      check("reset_state", 4'b0000);
      rst = 1'b1;

`ifdef JTFRAME_4WAY_FILTER_EN
      for (int i = 0; i < 3; i++) step("filt_short_hold", 1'b1, 4'b0001, 4'b0000);
      for (int i = 0; i < 8; i++) step("filt_after_short", 1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 4; i++) step("filt_settling", 1'b1, 4'b0001, 4'b0000);
      step("filt_latency", 1'b1, 4'b0001, 4'b0001);
      step("filt_steady", 1'b1, 4'b0001, 4'b0001);
`else
      step("first_edge_diag", 1'b1, 4'b0101, 4'b0100);
      step("passthru_1001", 1'b0, 4'b1001, 4'b1001);
      step("passthru_1111", 1'b0, 4'b1111, 4'b1111);

      step("seq_idle", 1'b1, 4'b0000, 4'b0000);
      step("seq_right", 1'b1, 4'b0001, 4'b0001);
      step("seq_upright_a", 1'b1, 4'b1001, 4'b0001);
      step("seq_upright_b", 1'b1, 4'b1001, 4'b0001);
      step("seq_up", 1'b1, 4'b1000, 4'b1000);

      step("fresh_idle", 1'b1, 4'b0000, 4'b0000);
      step("fresh_downleft", 1'b1, 4'b0110, 4'b0100);

      step("cancel_lr", 1'b1, 4'b0011, 4'b0000);
      step("cancel_lr_up", 1'b1, 4'b1011, 4'b1000);
      step("cancel_all", 1'b1, 4'b1111, 4'b0000);

      step("pre_reset_down", 1'b1, 4'b0100, 4'b0100);
      rst = 1'b0;
      #2;
      check("async_reset", 4'b0000);
      m_last = 4'b0000;
      rst    = 1'b1;
      step("post_reset_diag", 1'b1, 4'b1010, 4'b1000);

      // State keeps tracking with enable low, so a later diagonal holds the left
      step("track_left_off", 1'b0, 4'b0010, 4'b0010);
      step("track_diag_on", 1'b1, 4'b0110, 4'b0010);

      for (int i = 0; i < 400; i++) begin
         logic       en;
         logic [3:0] j;
         en = ($urandom_range(0, 3) != 0);
         j  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) j = joy8way;
         apply(en, j);
         check("random", m_exp);
         if (en) begin
            vectors++;
            assert ($countones(joy4way) <= 1) else begin
               miscompares++;
               $error("FAIL onehot: joy4way=%b expected at most one bit", joy4way);
            end
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jtframe_4wayjoy.md
JTFRAME_4WAYJOY -- requirements
Module: jtframe_4wayjoy

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-003 enable  input  1  1 = 4-way restriction active; 0 = 8-way pass-through.
REQ-004 joy8way  input  4  raw directions, active-high: bit0 right, bit1 left, bit2 down, bit3 up.
REQ-005 joy4way  output  4  filtered directions, same bit order and polarity, registered.
REQ-006 FILT_W, default 4, meaning: width of the stability counter, used only when the filter is compiled in.

Function
REQ-007 Output SHALL be a register; latency from joy8way to joy4way SHALL be exactly 1 clock (filter excluded).
REQ-008 enable=0: joy4way SHALL equal joy8way of the previous cycle, bit for bit; internal last-direction state SHALL still track the Function rules below.
REQ-009 enable=1: at most one bit of joy4way SHALL be set in any cycle.
REQ-010 Opposite cancel: right+left both set SHALL be treated as neither horizontal bit set; up+down likewise, before any further rule.
REQ-011 After cancel, no bits set: joy4way SHALL be 0; last-direction state SHALL be cleared to 0.
REQ-012 After cancel, exactly one bit set: joy4way SHALL be that bit; last-direction state SHALL be loaded with it.
REQ-013 Diagonal (one horizontal and one vertical bit), last-direction is one of the two: joy4way SHALL repeat last-direction (hold until released).
REQ-014 Diagonal, last-direction is 0 or not one of the two: joy4way SHALL be the vertical bit; last-direction SHALL be loaded with it.
REQ-015 Toggling enable SHALL take effect on the next clock with no glitch cycle of more than one bit set while enable=1.

Reset
REQ-016 While rst is low, joy4way SHALL be 4'b0000 and last-direction SHALL be 0, independent of clk.
REQ-017 First active edge after rst deassertion SHALL evaluate inputs per Function with last-direction=0.

Configuration
REQ-018 Macro JTFRAME_4WAY_FILTER_EN defined: the input fed to the restriction logic SHALL be a stable copy that updates only after joy8way holds the same value for 2^FILT_W consecutive clocks; latency is then 2^FILT_W+1 clocks; counter and stable copy reset to 0.
REQ-019 Macro not defined: no filter logic SHALL exist; latency per REQ-007.

Structure
REQ-020 A shared package SHALL hold the direction bit-index constants (RIGHT=0, LEFT=1, DOWN=2, UP=3) and the 4-bit direction type.
REQ-021 The stability filter SHALL be a sub-module jtframe_4wayjoy_filter, instantiated only under JTFRAME_4WAY_FILTER_EN.
REQ-022 The restriction logic SHALL be a single clocked process plus combinational next-state decode; no other sub-modules.

Verification
REQ-023 enable=0, joy8way=4'b1001 -> joy4way=4'b1001 one clock later.
REQ-024 enable=1, 0000 -> 0001 (right) -> 1001 (up+right) -> joy4way 0001 then stays 0001; then 1000 -> joy4way 1000.
REQ-025 enable=1, from 0000 directly to 0110 (down+left) -> joy4way=0100.
REQ-026 enable=1, joy8way=0011 (left+right) -> 0000; joy8way=1011 -> 1000.
REQ-027 rst low mid-sequence with joy4way=0100 -> joy4way=0000 immediately; after release with joy8way=1010 -> 1000.
REQ-028 Filter build, FILT_W=2: 0001 held 3 clocks then 0000 -> joy4way stays 0000; 0001 held 4 clocks -> 0001 appears 5 clocks after first application.
